// File: rtl/aucohl_sar_scan.sv
// Multi-channel SAR ADC controller: scans masked channels, runs one successive-approximation
// conversion per channel and hands tagged results out over a valid/ready register.
module aucohl_sar_scan #(
  parameter int SIZE = 10,
  parameter int NCH  = 4,
  parameter int SWW  = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            soc,
  input  logic            mode,
  input  logic [NCH-1:0]  ch_mask,
  input  logic [SWW-1:0]  swidth,
  input  logic            stop,
  input  logic            cmp,
  output logic            sample_n,
  output logic            dac_rst,
  output logic [SIZE-1:0] dac,
  output logic [CW-1:0]   ch_sel,
  output logic [SIZE-1:0] data,
  output logic [CW-1:0]   data_ch,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            eos,
  output logic            busy,
  output logic            overrun,
  input  logic            ovr_clr
);

  localparam int KW   = $clog2(SIZE);
  localparam int CNTW = (SWW > KW) ? SWW : KW;

  typedef enum logic [2:0] {IDLE, SEL, SAMPLE, CONV, DONE} state_t;

  // {found, index} of the lowest set mask bit at or above 'from'
  function automatic logic [CW:0] find_ch(input logic [NCH-1:0] m, input int from);
    find_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i] && i >= from) find_ch = {1'b1, CW'(i)};
  endfunction

  function automatic logic [SIZE-1:0] trial(input logic [CNTW-1:0] k);
    trial = '0;
    if (int'(k) < SIZE) trial = {{(SIZE-1){1'b0}}, 1'b1} << (SIZE - 1 - int'(k));
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic            mode_q, mode_d;
  logic [SWW-1:0]  sw_q, sw_d;
  logic            stop_pend_q, stop_pend_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] code_q, code_d;
  logic [SIZE-1:0] data_q, data_d;
  logic [CW-1:0]   data_ch_q, data_ch_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            eos_q, eos_d;
  logic            sample_n_q, sample_n_d;
  logic            dac_rst_q, dac_rst_d;
  logic [SIZE-1:0] dac_q, dac_d;
  logic            busy_q, busy_d;

  logic [CW:0] soc_first, nxt_hi, first_lo;
  logic        load, last_bit;

  always_comb begin
    soc_first = find_ch(ch_mask, 0);
    nxt_hi    = find_ch(mask_q, int'(ch_q) + 1);
    first_lo  = find_ch(mask_q, 0);
    load      = en && (state_q == DONE);
    last_bit  = (cnt_q == CNTW'(SIZE - 1));

    state_d     = state_q;
    ch_d        = ch_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    sw_d        = sw_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    stop_pend_d = stop_pend_q | (stop && (state_q != IDLE));
    eos_d       = 1'b0;

    if (en) begin
      case (state_q)
        IDLE: if (soc && soc_first[CW]) begin
          state_d = SEL;
          mask_d  = ch_mask;
          mode_d  = mode;
          sw_d    = swidth;
          ch_d    = soc_first[CW-1:0];
        end
        SEL: begin
          code_d  = '0;
          cnt_d   = '0;
          state_d = SAMPLE;
        end
        SAMPLE: begin
          if (cnt_q == CNTW'(sw_q)) begin
            cnt_d   = '0;
            state_d = CONV;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        CONV: begin
          if (cmp) code_d = code_q | trial(cnt_q);
          if (last_bit) begin
            state_d = DONE;
            eos_d   = ~nxt_hi[CW];
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        DONE: begin
          if (nxt_hi[CW]) begin
            state_d = SEL;
            ch_d    = nxt_hi[CW-1:0];
          end else if (mode_q && !(stop_pend_q || stop) && first_lo[CW]) begin
            state_d = SEL;
            ch_d    = first_lo[CW-1:0];
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == IDLE) stop_pend_d = 1'b0;

    // Analog-facing controls are registered copies of the next-state decode
    sample_n_d = (state_d != SAMPLE);
    dac_rst_d  = (state_d == SEL);
    busy_d     = (state_d != IDLE);
    dac_d      = (state_d == CONV) ? (code_d | trial(cnt_d)) : '0;

    data_d    = load ? code_q : data_q;
    data_ch_d = load ? ch_q : data_ch_q;
    valid_d   = load | (valid_q & ~data_ready);
    if (load && valid_q && !data_ready) ovr_d = 1'b1;
    else if (ovr_clr)                   ovr_d = 1'b0;
    else                                ovr_d = ovr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      mask_q      <= '0;
      mode_q      <= 1'b0;
      sw_q        <= '0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
      code_q      <= '0;
      data_q      <= '0;
      data_ch_q   <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      eos_q       <= 1'b0;
      sample_n_q  <= 1'b1;
      dac_rst_q   <= 1'b0;
      dac_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      sw_q        <= sw_d;
      stop_pend_q <= stop_pend_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      data_q      <= data_d;
      data_ch_q   <= data_ch_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      eos_q       <= eos_d;
      sample_n_q  <= sample_n_d;
      dac_rst_q   <= dac_rst_d;
      dac_q       <= dac_d;
      busy_q      <= busy_d;
    end
  end

  assign sample_n   = sample_n_q;
  assign dac_rst    = dac_rst_q;
  assign dac        = dac_q;
  assign ch_sel     = ch_q;
  assign data       = data_q;
  assign data_ch    = data_ch_q;
  assign data_valid = valid_q;
  assign eos        = eos_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_aucohl_sar_scan.sv
// Directed bench for aucohl_sar_scan with a per-channel comparator model and result scoreboard.
module tb_aucohl_sar_scan;
  localparam int SIZE = 8;
  localparam int NCH  = 4;
  localparam int SWW  = 4;
  localparam int CW   = 2;

  logic            clk = 1'b0;
  logic            rst, en, soc, mode, stop, cmp, data_ready, ovr_clr;
  logic [NCH-1:0]  ch_mask;
  logic [SWW-1:0]  swidth;
  logic            sample_n, dac_rst, data_valid, eos, busy, overrun;
  logic [SIZE-1:0] dac, data;
  logic [CW-1:0]   ch_sel, data_ch;

  logic [7:0]         vin [NCH];
  logic [CW+SIZE-1:0] sb [$];
  logic [CW+SIZE-1:0] sb_e;
  int tests = 0, fails = 0, n_acc = 0, n_eos = 0;
  int cyc, e0, a0;
  logic [7:0] tv, held;

  aucohl_sar_scan #(.SIZE(SIZE), .NCH(NCH), .SWW(SWW)) dut (
    .clk(clk), .rst(rst), .en(en), .soc(soc), .mode(mode), .ch_mask(ch_mask),
    .swidth(swidth), .stop(stop), .cmp(cmp), .sample_n(sample_n), .dac_rst(dac_rst),
    .dac(dac), .ch_sel(ch_sel), .data(data), .data_ch(data_ch), .data_valid(data_valid),
    .data_ready(data_ready), .eos(eos), .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;
  assign cmp = (vin[ch_sel] >= dac);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // Scoreboard: every accepted result must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst) begin
      if (eos) n_eos++;
      if (data_valid && data_ready) begin
        n_acc++;
        $display("[TB] accept ch%0d data %02h", data_ch, data);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL sb_unexpected: observed ch%0d %0h expected none", data_ch, data);
        end else begin
          sb_e = sb.pop_front();
          chk("sb_data", 32'(data), 32'(sb_e[SIZE-1:0]));
          chk("sb_ch", 32'(data_ch), 32'(sb_e[CW+SIZE-1:SIZE]));
        end
      end
    end
  end

  task automatic do_soc(input logic m, input logic [NCH-1:0] msk, input logic [SWW-1:0] sw);
    @(posedge clk); #1;
    soc = 1'b1; mode = m; ch_mask = msk; swidth = sw;
    @(posedge clk); #1;
    soc = 1'b0;
  endtask

  task automatic wait_valid(input int init, input int maxc, output int c);
    bit got = 0;
    c = init;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge clk); c++;
      @(negedge clk);
      if (data_valid) got = 1;
    end
    if (!got) timeout("wait_valid");
  endtask

  task automatic wait_idle(input int maxc);
    bit got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) timeout("wait_idle");
  endtask

  task automatic wait_eos(input int maxc);
    bit got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (eos) got = 1;
    end
    if (!got) timeout("wait_eos");
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; soc = 1'b0; mode = 1'b0; stop = 1'b0;
    data_ready = 1'b1; ovr_clr = 1'b0; ch_mask = '0; swidth = '0;
    vin[0] = 8'h10; vin[1] = 8'h5A; vin[2] = 8'h20; vin[3] = 8'hC3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sample_n", 32'(sample_n), 32'd1);
    chk("rst_outs", 32'({dac_rst, dac, ch_sel, data, data_ch, data_valid, eos, busy, overrun}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: single scan over ch1, ch3
    e0 = n_eos;
    sb.push_back({2'd1, 8'h5A});
    sb.push_back({2'd3, 8'hC3});
    do_soc(1'b0, 4'b1010, 4'd2);
    wait_valid(1, 40, cyc);
    chk("t1_latency", 32'(cyc), 32'd14);
    wait_valid(0, 40, cyc);
    chk("t1_period", 32'(cyc), 32'd13);
    wait_idle(40);
    settle();
    chk("t1_eos_count", 32'(n_eos - e0), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_overrun", 32'(overrun), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: boundary codes on ch0, with DAC trial sequence for 0x00
    vin[0] = 8'h00;
    sb.push_back({2'd0, 8'h00});
    do_soc(1'b0, 4'b0001, 4'd0);
    @(negedge clk);
    chk("t2_dac_rst", 32'(dac_rst), 32'd1);
    chk("t2_dac_sel", 32'(dac), 32'd0);
    @(negedge clk);
    chk("t2_sample_n", 32'(sample_n), 32'd0);
    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk);
      tv = 8'h80 >> k;
      chk("t2_dac_seq", 32'(dac), 32'(tv));
    end
    wait_idle(40);
    settle();
    vin[0] = 8'hFF;
    sb.push_back({2'd0, 8'hFF});
    do_soc(1'b0, 4'b0001, 4'd0);
    wait_idle(40);
    settle();
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: continuous ch0 with consumer stalled -> overrun behaviour
    data_ready = 1'b0;
    vin[0] = 8'h33;
    do_soc(1'b1, 4'b0001, 4'd1);
    wait_eos(40);
    @(negedge clk);
    chk("t3_valid", 32'(data_valid), 32'd1);
    chk("t3_data1", 32'(data), 32'h33);
    chk("t3_ovr_first", 32'(overrun), 32'd0);
    vin[0] = 8'h44;
    wait_eos(40);
    @(negedge clk);
    chk("t3_ovr_set", 32'(overrun), 32'd1);
    chk("t3_data_latest", 32'(data), 32'h44);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("t3_ovr_clr", 32'(overrun), 32'd0);
    wait_eos(40);
    ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("t3_ovr_set_wins", 32'(overrun), 32'd1);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle(60);
    sb.push_back({2'd0, 8'h44});
    data_ready = 1'b1;
    settle();
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_valid_drained", 32'(data_valid), 32'd0);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;

    // 4: continuous all channels, stop during ch2 conversion
    vin[0] = 8'h11; vin[1] = 8'h22; vin[2] = 8'h33; vin[3] = 8'h44;
    e0 = n_eos; a0 = n_acc;
    for (int c = 0; c < NCH; c++) sb.push_back({CW'(c), vin[c]});
    do_soc(1'b1, 4'b1111, 4'd0);
    begin
      bit got = 0;
      for (int i = 0; i < 80 && !got; i++) begin
        @(negedge clk);
        if (ch_sel == 2'd2) got = 1;
      end
      if (!got) timeout("t4_wait_ch2");
    end
    repeat (4) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle(80);
    settle();
    chk("t4_eos_count", 32'(n_eos - e0), 32'd1);
    chk("t4_accepts", 32'(n_acc - a0), 32'd4);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    repeat (20) @(negedge clk);
    chk("t4_no_restart", 32'(busy), 32'd0);
    chk("t4_accepts_after", 32'(n_acc - a0), 32'd4);

    // 5: ignored socs and enable freeze
    do_soc(1'b0, 4'b0000, 4'd0);
    @(negedge clk);
    chk("t5_mask0_idle", 32'(busy), 32'd0);
    a0 = n_acc;
    vin[0] = 8'h5A;
    sb.push_back({2'd0, 8'h5A});
    do_soc(1'b0, 4'b0001, 4'd0);
    repeat (3) @(posedge clk);
    do_soc(1'b1, 4'b1111, 4'd3);
    wait_idle(60);
    settle();
    chk("t5_soc_busy_ignored", 32'(n_acc - a0), 32'd1);
    vin[0] = 8'h96;
    sb.push_back({2'd0, 8'h96});
    do_soc(1'b0, 4'b0001, 4'd0);
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    chk("t5_dac_frozen_a", 32'(dac), 32'hA0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_dac_frozen_b", 32'(dac), 32'hA0);
    @(posedge clk); #1 en = 1'b1;
    wait_valid(10, 40, cyc);
    chk("t5_en_latency", 32'(cyc), 32'd17);
    settle();
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: reset mid-SAMPLE, then a fresh conversion
    do_soc(1'b0, 4'b0001, 4'd5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_in_sample", 32'(sample_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_sample_n", 32'(sample_n), 32'd1);
    chk("t6_rst_outs", 32'({dac_rst, dac, ch_sel, data, data_ch, data_valid, eos, busy, overrun}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    vin[0] = 8'h5A;
    sb.push_back({2'd0, 8'h5A});
    do_soc(1'b0, 4'b0001, 4'd5);
    wait_valid(1, 40, cyc);
    chk("t6_latency", 32'(cyc), 32'd17);
    settle();
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
